// File: rtl/trace_buf_capture_ctrl.sv
// Trace-buffer address/write controller: arm, circular pre/post-trigger or linear capture, in-order readback.
// Optional write counter on sample_cnt when TRACE_BUF_SAMPLE_CNT_EN is defined.
module trace_buf_capture_ctrl #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  mode,
    input  logic                  trigger,
    input  logic                  sample_en,
    input  logic [ADDR_WIDTH-1:0] post_len,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic [31:0]           rd_offset,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [NUM_CH-1:0]     wr_en,
    output logic                  buf_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  triggered,
    output logic                  wrapped,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [31:0]           sample_cnt
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_POST, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] remain_q, remain_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] post_len_q, post_len_d;
    logic [NUM_CH-1:0]     ch_mask_q, ch_mask_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d, rd_addr_d, trig_addr_d;
    logic [NUM_CH-1:0]     wr_en_d;
    logic                  triggered_d, wrapped_d, busy_d, done_d;
    logic                  wr_go;
    logic                  capturing;
    logic                  unused_rd_offset;

    assign buf_en           = 1'b1;
    assign unused_rd_offset = ^rd_offset[31:ADDR_WIDTH];

    // Next-state, write path, trigger capture and readback address.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remain_d    = remain_q;
        mode_d      = mode_q;
        post_len_d  = post_len_q;
        ch_mask_d   = ch_mask_q;
        wr_addr_d   = wr_addr;
        wr_en_d     = '0;
        trig_addr_d = trig_addr;
        triggered_d = triggered;
        wrapped_d   = wrapped;
        wr_go       = 1'b0;
        capturing   = (state_q == ST_PRE) || (state_q == ST_POST);
        // Offset 0 maps to the oldest valid sample once the buffer has wrapped.
        rd_addr_d   = ADDR_WIDTH'((wrapped ? ptr_q : '0) + rd_offset[ADDR_WIDTH-1:0]);

        if (arm) begin
            state_d     = ST_PRE;
            ptr_d       = '0;
            remain_d    = '0;
            mode_d      = mode;
            post_len_d  = post_len;
            ch_mask_d   = ch_mask;
            trig_addr_d = '0;
            triggered_d = 1'b0;
            wrapped_d   = 1'b0;
        end else if (capturing) begin
            if (sample_en) begin
                wr_go     = 1'b1;
                wr_en_d   = ch_mask_q;
                wr_addr_d = ptr_q;
                ptr_d     = ADDR_WIDTH'(ptr_q + 1'b1);
                if (ptr_q == ADDR_MAX) wrapped_d = 1'b1;
            end
            if (abort) begin
                state_d = ST_DONE;
            end else if (state_q == ST_PRE) begin
                if (mode_q) begin
                    if (sample_en && ptr_q == ADDR_MAX) state_d = ST_DONE;
                end else if (trigger) begin
                    // A sample written with the trigger is the trigger sample, not a post sample.
                    triggered_d = 1'b1;
                    trig_addr_d = ptr_q;
                    remain_d    = post_len_q;
                    state_d     = (post_len_q == '0) ? ST_DONE : ST_POST;
                end
            end else if (sample_en) begin
                remain_d = ADDR_WIDTH'(remain_q - 1'b1);
                if (remain_q == ADDR_WIDTH'(1)) state_d = ST_DONE;
            end
        end

        busy_d = (state_d == ST_PRE) || (state_d == ST_POST);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            remain_q   <= '0;
            mode_q     <= 1'b0;
            post_len_q <= '0;
            ch_mask_q  <= '0;
            wr_addr    <= '0;
            wr_en      <= '0;
            rd_addr    <= '0;
            trig_addr  <= '0;
            triggered  <= 1'b0;
            wrapped    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            remain_q   <= remain_d;
            mode_q     <= mode_d;
            post_len_q <= post_len_d;
            ch_mask_q  <= ch_mask_d;
            wr_addr    <= wr_addr_d;
            wr_en      <= wr_en_d;
            rd_addr    <= rd_addr_d;
            trig_addr  <= trig_addr_d;
            triggered  <= triggered_d;
            wrapped    <= wrapped_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

`ifdef TRACE_BUF_SAMPLE_CNT_EN
    // Saturating count of writes issued since the last arm.
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn || arm) begin
            cnt_q <= '0;
        end else if (wr_go && cnt_q != 32'hFFFF_FFFF) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign sample_cnt = cnt_q;
`else
    logic unused_wr_go;
    assign unused_wr_go = wr_go;
    assign sample_cnt   = '0;
`endif

endmodule
